// File: rtl/chebyshev_sequencer.sv
// Sequences one Chebyshev-term pass through an external product datapath and sums the results.
// Optional CHEB_ACC_SAT_EN: saturating accumulator instead of two's-complement wrap.

module cheb_coeff_slot #(
  parameter int CL = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          we,
  input  logic [CL-1:0] d,
  output logic [CL-1:0] q
);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  q <= '0;
    else if (we)  q <= d;
  end
endmodule

module chebyshev_sequencer #(
  parameter int WL        = 4,
  parameter int CL        = 4,
  parameter int WIDENING  = 0,
  parameter int NUM_COEFF = 4,
  parameter int PIPE_LAT  = 2,
  parameter int ACC_GUARD = 2,
  localparam int OUT      = 2*WL + CL + WIDENING,
  localparam int ACC_W    = OUT + ACC_GUARD,
  localparam int AW       = $clog2(NUM_COEFF)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic signed [CL-1:0]    cfg_coeff,
  input  logic                    start,
  input  logic signed [WL-1:0]    x_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] result,
  output logic signed [WL-1:0]    dp_data,
  output logic signed [CL-1:0]    dp_coeff,
  input  logic signed [OUT-1:0]   dp_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_COEFF - 1);

  state_t                        state, nxt;
  logic [AW-1:0]                 idx;
  logic signed [WL-1:0]          x_q;
  logic signed [ACC_W-1:0]       acc, acc_sum, ext;
  logic [PIPE_LAT:1]             vld_pipe;
  logic [NUM_COEFF-1:0][CL-1:0]  coeff_q;
  logic                          accept, issue, capture, pend, wr_en;

  assign accept  = (state == S_IDLE) && start;
  assign issue   = (state == S_ISSUE);
  assign capture = vld_pipe[PIPE_LAT];
  assign wr_en   = cfg_we && (state == S_IDLE);

  // Address decode per slot; indices beyond NUM_COEFF match no slot and are dropped.
  for (genvar i = 0; i < NUM_COEFF; i++) begin : g_slot
    cheb_coeff_slot #(.CL(CL)) u_slot (
      .clock  (clock),
      .resetn (resetn),
      .we     (wr_en && (cfg_addr == AW'(i))),
      .d      (cfg_coeff),
      .q      (coeff_q[i])
    );
  end

  // Issues still in flight that will not be captured this cycle.
  always_comb begin
    pend = 1'b0;
    for (int i = 1; i < PIPE_LAT; i++) pend = pend | vld_pipe[i];
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start)       nxt = S_ISSUE;
      S_ISSUE: if (idx == LAST) nxt = S_DRAIN;
      S_DRAIN: if (!pend)       nxt = S_DONE;
      S_DONE:                   nxt = S_IDLE;
      default:                  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nxt;
  end

  assign busy     = (state == S_ISSUE) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign dp_data  = issue ? x_q : '0;
  assign dp_coeff = issue ? coeff_q[idx] : '0;

  assign ext = ACC_W'(dp_result);

`ifdef CHEB_ACC_SAT_EN
  logic signed [ACC_W:0] sum_w;
  always_comb begin
    sum_w = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
    if (sum_w[ACC_W] != sum_w[ACC_W-1])
      acc_sum = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_sum = sum_w[ACC_W-1:0];
  end
`else
  assign acc_sum = acc + ext;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      idx      <= '0;
      acc      <= '0;
      result   <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      for (int i = 2; i <= PIPE_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (accept) begin
        x_q <= x_in;
        idx <= '0;
        acc <= '0;
      end else begin
        if (issue && idx != LAST) idx <= idx + AW'(1);
        if (capture)              acc <= acc_sum;
      end
      // Final capture lands on the same edge that enters DONE.
      if (state == S_DRAIN && nxt == S_DONE) result <= capture ? acc_sum : acc;
    end
  end

endmodule

// File: tb/tb_chebyshev_sequencer.sv
// Directed bench for chebyshev_sequencer; datapath modelled as dp_data^2*dp_coeff delayed PIPE_LAT.

module tb_chebyshev_sequencer;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // default-parameter instance
  logic               cfg_we = 1'b0;
  logic [1:0]         cfg_addr = '0;
  logic signed [3:0]  cfg_coeff = '0;
  logic               start = 1'b0;
  logic signed [3:0]  x_in = '0;
  logic               busy, done;
  logic signed [13:0] result;
  logic signed [3:0]  dp_data, dp_coeff;
  logic signed [11:0] dp_result;
  logic signed [11:0] p0 [2];

  // NUM_COEFF=8, ACC_GUARD=0 instance
  logic               b_cfg_we = 1'b0;
  logic [2:0]         b_cfg_addr = '0;
  logic signed [3:0]  b_cfg_coeff = '0;
  logic               b_start = 1'b0;
  logic signed [3:0]  b_x_in = '0;
  logic               b_busy, b_done;
  logic signed [11:0] b_result;
  logic signed [3:0]  b_dp_data, b_dp_coeff;
  logic signed [11:0] b_dp_result;
  logic signed [11:0] p1 [2];

  int npass = 0;
  int ntot  = 0;

  chebyshev_sequencer dut (
    .clock(clock), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_coeff(cfg_coeff), .start(start), .x_in(x_in), .busy(busy), .done(done),
    .result(result), .dp_data(dp_data), .dp_coeff(dp_coeff), .dp_result(dp_result)
  );

  chebyshev_sequencer #(.NUM_COEFF(8), .ACC_GUARD(0)) dut_b (
    .clock(clock), .resetn(resetn), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr),
    .cfg_coeff(b_cfg_coeff), .start(b_start), .x_in(b_x_in), .busy(b_busy), .done(b_done),
    .result(b_result), .dp_data(b_dp_data), .dp_coeff(b_dp_coeff), .dp_result(b_dp_result)
  );

  always @(posedge clock) begin
    p0[0] <= 12'(int'(dp_data) * int'(dp_data) * int'(dp_coeff));
    p0[1] <= p0[0];
    p1[0] <= 12'(int'(b_dp_data) * int'(b_dp_data) * int'(b_dp_coeff));
    p1[1] <= p1[0];
  end
  assign dp_result   = p0[1];
  assign b_dp_result = p1[1];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic wr(input int a, input int v);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_coeff = 4'(v);
    tick();
    cfg_we = 1'b0;
  endtask

  // One pass with start in cycle 0; checks cycles 1..8 against hand-derived values.
  task automatic do_pass(input string tag, input int x, input int c0, input int c1,
                         input int c2, input int c3, input int exp_res,
                         input bit inject, input bit wr_same);
    int cs[4];
    int ec;
    cs = '{c0, c1, c2, c3};
    start = 1'b1; x_in = 4'(x);
    if (wr_same) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_coeff = 4'sd3; end
    tick();
    start = 1'b0; x_in = '0; cfg_we = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      ec = (c <= 4) ? cs[c-1] : 0;
      check({tag, "_busy"},  int'(busy), (c <= 6) ? 1 : 0);
      check({tag, "_done"},  int'(done), (c == 7) ? 1 : 0);
      check({tag, "_coeff"}, int'(dp_coeff), ec);
      check({tag, "_data"},  int'(dp_data), (c <= 4) ? x : 0);
      if (c >= 7) check({tag, "_result"}, int'(result), exp_res);
      if (inject && c == 2) begin start = 1'b1; x_in = 4'sd1; end
      if (inject && c == 3) begin
        start = 1'b0; x_in = '0;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_coeff = 4'sd7;
      end
      if (c == 4) cfg_we = 1'b0;
      tick();
    end
  endtask

  initial begin
    // reset held with start and write asserted
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_coeff = 4'sd5;
    repeat (3) tick();
    check("rst_busy",   int'(busy), 0);
    check("rst_done",   int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_data",   int'(dp_data), 0);
    check("rst_coeff",  int'(dp_coeff), 0);
    start = 1'b0; cfg_we = 1'b0; resetn = 1'b1;
    tick();
    check("rel_busy", int'(busy), 0);
    check("rel_done", int'(done), 0);
    do_pass("rst_nowrite", 4, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // basic pass: 16*(2+5+0-1) = 96
    wr(0, 2); wr(1, 5); wr(2, 0); wr(3, -1);
    do_pass("basic", 4, 2, 5, 0, -1, 96, 1'b0, 1'b0);
    do_pass("ignored", 4, 2, 5, 0, -1, 96, 1'b1, 1'b0);
    do_pass("after_ign", 4, 2, 5, 0, -1, 96, 1'b0, 1'b0);
    // same-cycle write of coeff[0]=3 with start: 48+80+0-16 = 112
    do_pass("wr_start", 4, 3, 5, 0, -1, 112, 1'b0, 1'b1);

    // reset mid-pass in cycle 4
    start = 1'b1; x_in = 4'sd4;
    tick();
    start = 1'b0; x_in = '0;
    repeat (3) tick();
    check("mid_busy_pre", int'(busy), 1);
    resetn = 1'b0;
    #1;
    check("mid_busy",   int'(busy), 0);
    check("mid_done",   int'(done), 0);
    check("mid_result", int'(result), 0);
    check("mid_data",   int'(dp_data), 0);
    check("mid_coeff",  int'(dp_coeff), 0);
    tick();
    resetn = 1'b1;
    tick();
    do_pass("post_mid", 4, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // back-to-back with start held high
    wr(0, 2); wr(1, 5); wr(2, 0); wr(3, -1);
    start = 1'b1; x_in = 4'sd4;
    tick();
    for (int c = 1; c <= 16; c++) begin
      check("b2b_done", int'(done), (c == 7 || c == 15) ? 1 : 0);
      check("b2b_busy", int'(busy), ((c >= 1 && c <= 6) || (c >= 9 && c <= 14)) ? 1 : 0);
      if (c == 7 || c == 15) check("b2b_result", int'(result), 96);
      if (c == 15) start = 1'b0;
      tick();
    end

    // wide pass: 8 * 64 * 7 = 3584 in a 12-bit accumulator
    for (int a = 0; a < 8; a++) begin
      b_cfg_we = 1'b1; b_cfg_addr = 3'(a); b_cfg_coeff = 4'sd7;
      tick();
    end
    b_cfg_we = 1'b0;
    b_start = 1'b1; b_x_in = -4'sd8;
    tick();
    b_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check("wide_done", int'(b_done), (c == 11) ? 1 : 0);
      if (c <= 8) check("wide_coeff", int'(b_dp_coeff), 7);
`ifdef CHEB_ACC_SAT_EN
      if (c == 11) check("wide_result", int'(b_result), 2047);
`else
      if (c == 11) check("wide_result", int'(b_result), -512);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/chebyshev_sequencer.md
Name: chebyshev_sequencer

Overview:
- Controller that sequences one Chebyshev-term evaluation pass through the external product datapath.
- Holds a bank of NUM_COEFF signed coefficients, loaded over a simple write port.
- On start, issues one (x, coeff[k]) pair per cycle to the datapath, collects each dp_result PIPE_LAT cycles later, and accumulates the sum.
- Sits between the configuration/host logic and the chebyshev datapath; the datapath itself stays purely arithmetic.

Parameters:
- WL, 4: word length of x / dp_data (signed)
- CL, 4: word length of coefficients (signed)
- WIDENING, 0: extra datapath output bits; OUT = 2*WL+CL+WIDENING
- NUM_COEFF, 4: number of coefficients per pass (>=2); AW = clog2(NUM_COEFF) (localparam)
- PIPE_LAT, 2: datapath latency in cycles from dp_data/dp_coeff to dp_result (>=1)
- ACC_GUARD, 2: accumulator guard bits; ACC_W = OUT+ACC_GUARD

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  AW  coefficient index
- cfg_coeff  in  CL  signed coefficient value
- start  in  1  start a pass; sampled only in IDLE
- x_in  in  WL  signed evaluation point, latched on start accept
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse; result valid
- result  out  ACC_W  signed accumulated sum
- dp_data  out  WL  operand to datapath
- dp_coeff  out  CL  coefficient to datapath
- dp_result  in  OUT  signed datapath output

Behaviour:
- Reset (async, resetn=0): state=IDLE; coefficient bank, busy, done, result, dp_data, dp_coeff, accumulator, index and valid pipe all cleared to 0. Applies immediately, including mid-pass; no partial result is retained.
- FSM states:
  - IDLE -> ISSUE on start=1.
  - ISSUE -> DRAIN after the NUM_COEFF-th issue.
  - DRAIN -> DONE when the valid pipe is empty.
  - DONE -> IDLE unconditionally.
- Start accept (start=1 in IDLE, cycle 0): latch x_in, clear accumulator, index=0.
- Issue timing: dp_data=x and dp_coeff=coeff[k] during cycle k+1, for k=0..NUM_COEFF-1. Outside ISSUE, both are driven 0.
- Capture: a valid shift register of depth PIPE_LAT tracks issues. Issue k's dp_result is sampled at the end of cycle k+1+PIPE_LAT and sign-extended to ACC_W. Then acc <= acc + sext(dp_result).
- busy=1 during cycles 1..NUM_COEFF+PIPE_LAT.
- done=1 for exactly cycle NUM_COEFF+PIPE_LAT+1. result is updated from the accumulator on that cycle and holds until the next done; it is not cleared by a new start.
- Default arithmetic: two's-complement wrap in ACC_W.
- Start while not IDLE (ISSUE/DRAIN/DONE): ignored, no queueing.
- Coefficient writes:
  - cfg_we in IDLE writes coeff[cfg_addr] at the clock edge.
  - Writes when not IDLE are dropped.
  - cfg_addr >= NUM_COEFF is dropped.
  - cfg_we and start in the same IDLE cycle: the write commits and the pass uses the new value.
- Back-to-back passes: start is accepted in IDLE the cycle after done; the minimum pass period is NUM_COEFF+PIPE_LAT+2 cycles.

Optional Feature:
- Macro CHEB_ACC_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation is sticky for the pass: once clamped, later additions re-saturate from the clamp value, with no wrap.
- Undefined: plain two's-complement wrap; no saturation logic synthesised.

Test Plan:
Bench models the datapath as dp_result = dp_data*dp_data*dp_coeff delayed by PIPE_LAT; defaults unless stated.
1. Reset: hold resetn=0 for 3 cycles with start=1 and cfg_we=1 -> busy=done=result=dp_data=dp_coeff=0, no state change; release -> IDLE.
2. Basic pass: write coeff {2,5,0,-1}, start with x_in=4 -> dp_coeff sequence 2,5,0,-1 in cycles 1..4; done pulse in cycle 7 only; result=32+80+0-16=96; busy high in cycles 1..6.
3. Ignored events: during the step-2 pass, pulse start (x_in=1) in cycle 2 and cfg_we addr0=7 in cycle 3 -> result still 96, single done, coeff[0] still 2 on the next pass. Same-cycle write+start in IDLE with addr0=3 -> first product uses 3.
4. Reset mid-pass: start the step-2 pass, drop resetn in cycle 4 -> outputs 0 immediately, coefficients 0. After release, a pass with x=4 gives result=0.
5. Wrap/saturation: NUM_COEFF=8, ACC_GUARD=0 (ACC_W=12), all coeff=7, x=-8 -> without CHEB_ACC_SAT_EN result=3584-4096=-512; with it, result=2047.
6. Back-to-back: start held high continuously with the step-2 setup -> done pulses in cycles 7 and 15, both result=96.
